wb_sequencer: RTL



---
 rtl/wb_pkg.sv | 84 ++++++++
 rtl/wb_sequencer.sv | 79 +++++++
 2 files changed

// File: rtl/wb_pkg.sv
// ============================================================
// wb_pkg : shared kind codes, select encodings, output decode
// Revision: 1.0
// ============================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_RT   = 3'd1,
    KIND_LOAD = 3'd2,
    KIND_RD   = 3'd3,
    KIND_JAL  = 3'd4,
    KIND_PUSH = 3'd5,
    KIND_POP  = 3'd6,
    KIND_RSVD = 3'd7
  } wb_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_RT = 2'b00;
  localparam logic [1:0] SEL_SP = 2'b01;
  localparam logic [1:0] SEL_RA = 2'b10;
  localparam logic [1:0] SEL_RD = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [4:0] REG_SP = 5'd29;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] wr_sel;
    logic [1:0] wd_sel;
    logic       reg_write;
  } wb_out_t;

  // Moore decode of state plus latched request; the zero-register guard only
  // ever suppresses rt/rd targets.
  function automatic wb_out_t wb_decode(input state_e st, input wb_kind_e kind,
                                        input logic [4:0] rt, input logic [4:0] rd);
    wb_out_t o;
    o = '0;
    case (st)
      ST_WR1: begin
        o.busy = 1'b1;
        o.done = (kind != KIND_POP);
        o.err  = (kind == KIND_RSVD);
        case (kind)
          KIND_RT:   begin o.wr_sel = SEL_RT; o.wd_sel = WD_ALU; o.reg_write = 1'b1; end
          KIND_LOAD: begin o.wr_sel = SEL_RT; o.wd_sel = WD_MEM; o.reg_write = 1'b1; end
          KIND_RD:   begin o.wr_sel = SEL_RD; o.wd_sel = WD_ALU; o.reg_write = 1'b1; end
          KIND_JAL:  begin o.wr_sel = SEL_RA; o.wd_sel = WD_PC;  o.reg_write = 1'b1; end
          KIND_PUSH: begin o.wr_sel = SEL_SP; o.wd_sel = WD_ALU; o.reg_write = 1'b1; end
          KIND_POP:  begin o.wr_sel = SEL_RT; o.wd_sel = WD_MEM; o.reg_write = 1'b1; end
          default:   begin o.wr_sel = SEL_RT; o.wd_sel = WD_ALU; o.reg_write = 1'b0; end
        endcase
        if ((o.wr_sel == SEL_RT && rt == 5'd0) || (o.wr_sel == SEL_RD && rd == 5'd0))
          o.reg_write = 1'b0;
      end
      ST_WR2: begin
        o.busy      = 1'b1;
        o.done      = 1'b1;
        o.wr_sel    = SEL_SP;
        o.wd_sel    = WD_ALU;
        o.reg_write = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_sequencer.sv
// ============================================================
// wb_sequencer : one/two-cycle register-bank writeback sequencer
// Revision: 1.0
// ============================================================
`default_nettype none

module wb_sequencer
  import wb_pkg::*;
#(
  parameter int SP_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] wb_kind,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] wr_sel,
  output logic [1:0] wd_sel,
  output logic       reg_write,
  output logic [7:0] sp_step
);

  state_e     state, state_n;
  wb_kind_e   kind_q, kind_n;
  logic [4:0] rt_q, rt_n, rd_q, rd_n;
  wb_out_t    outs_q, outs_n;

  always_comb begin
    state_n = state;
    kind_n  = kind_q;
    rt_n    = rt_q;
    rd_n    = rd_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_WR1;
          kind_n  = wb_kind_e'(wb_kind);
          rt_n    = rt;
          rd_n    = rd;
        end
      end
      ST_WR1:  state_n = (kind_q == KIND_POP) ? ST_WR2 : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Decoding the next state lets the outputs come straight from flops.
    outs_n = wb_decode(state_n, kind_n, rt_n, rd_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      kind_q <= KIND_NONE;
      rt_q   <= 5'd0;
      rd_q   <= 5'd0;
      outs_q <= '0;
    end else begin
      state  <= state_n;
      kind_q <= kind_n;
      rt_q   <= rt_n;
      rd_q   <= rd_n;
      outs_q <= outs_n;
    end
  end

  assign busy      = outs_q.busy;
  assign done      = outs_q.done;
  assign err       = outs_q.err;
  assign wr_sel    = outs_q.wr_sel;
  assign wd_sel    = outs_q.wd_sel;
  assign reg_write = outs_q.reg_write;
  assign sp_step   = 8'(SP_STEP);

endmodule

`default_nettype wire
